fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/fetch_pc_gen.sv | 45 ++++
 rtl/fetch_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch types and constants: canonical NOP, default reset PC, IF/ID record.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        misalign;
        logic        oor;
    } ifid_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC select and PC register; iaddr is pc_q with zero added latency.
// Priority redirect > flush > stall > advance; advance_o flags a normal +4 step.
module fetch_pc_gen
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic        advance_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d      = pc_q;
        advance_o = 1'b0;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (flush_i || stall_i) begin
            pc_d = pc_q;
        end else begin
            // Plain 32-bit add: wraps FFFF_FFFC -> 0 by construction.
            pc_d      = pc_q + 32'd4;
            advance_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC gen, IF/ID register with misalign/out-of-range faults, fetch counter.
// One-cycle fetch latency; stall holds PC and IF/ID, redirect/flush squash IF/ID.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_misalign_o,
    output logic        ifid_oor_o,
    output logic [31:0] fetch_count_o
);

    // 33-bit limit so IMEM_WORDS*4 == 2^32 still compares correctly.
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;

    localparam ifid_t IFID_RESET = '{
        valid:    1'b0,
        pc:       32'h0,
        pc4:      32'h0,
        instr:    NOP_INSTR,
        misalign: 1'b0,
        oor:      1'b0
    };

    logic [31:0] pc;
    logic        advance;
    logic        misalign;
    logic        oor;
    ifid_t       ifid_q;
    ifid_t       ifid_d;
    logic [31:0] count_q;
    logic [31:0] count_d;

    fetch_pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pc_gen (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_o             (pc),
        .advance_o        (advance)
    );

    assign iaddr    = pc;
    assign misalign = (pc[1:0] != 2'b00);
    assign oor      = ({1'b0, pc} >= IMEM_BYTES);

    always_comb begin
        ifid_d  = ifid_q;
        count_d = count_q;
        if (advance) begin
            ifid_d.valid    = 1'b1;
            ifid_d.pc       = pc;
            ifid_d.pc4      = pc + 32'd4;
            ifid_d.instr    = (misalign || oor) ? NOP_INSTR : idata;
            ifid_d.misalign = misalign;
            ifid_d.oor      = oor;
            count_d         = count_q + 32'd1;
        end else if (redirect_valid_i || flush_i) begin
            ifid_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q  <= IFID_RESET;
            count_q <= 32'h0;
        end else begin
            ifid_q  <= ifid_d;
            count_q <= count_d;
        end
    end

    // A squashed entry keeps stale fields internally; mask them at the port.
    assign ifid_valid_o    = ifid_q.valid;
    assign ifid_pc_o       = ifid_q.pc;
    assign ifid_pc4_o      = ifid_q.pc4;
    assign ifid_instr_o    = ifid_q.valid ? ifid_q.instr : NOP_INSTR;
    assign ifid_misalign_o = ifid_q.valid & ifid_q.misalign;
    assign ifid_oor_o      = ifid_q.valid & ifid_q.oor;
    assign fetch_count_o   = count_q;

endmodule
